// File: rtl/cci_mpf_shim_vtp_pt_fim_port.sv
// Page-table walker port onto a shared memory interface: one outstanding
// tagged line read, and a credit-limited stream of tagged message writes.
module cci_mpf_shim_vtp_pt_fim_port #(
    parameter int          MAX_WRITES = 4,
    parameter logic [15:0] RD_TAG     = 16'hF0A0,
    parameter logic [15:0] WR_TAG     = 16'hF0A1
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         readEn,
    input  logic [41:0]  readAddr,
    output logic         readRdy,
    output logic         readDataEn,
    output logic [511:0] readData,

    input  logic         writeEn,
    input  logic [41:0]  writeAddr,
    input  logic [63:0]  writeData,
    output logic         writeRdy,

    output logic         rdReqValid,
    output logic [41:0]  rdReqAddr,
    output logic [15:0]  rdReqTag,
    input  logic         rdReqAlmFull,

    input  logic         rdRspValid,
    input  logic [15:0]  rdRspTag,
    input  logic [511:0] rdRspData,

    output logic         wrReqValid,
    output logic [41:0]  wrReqAddr,
    output logic [15:0]  wrReqTag,
    output logic [511:0] wrReqData,
    input  logic         wrReqAlmFull,

    input  logic         wrRspValid,
    input  logic [15:0]  wrRspTag,

    output logic         errUnexpected
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0] readState;
    logic [1:0] readStateNext;
    logic [3:0] wrCnt;
    logic [3:0] wrCntNext;
    logic       readyEn;
    logic       readAccept;
    logic       writeAccept;
    logic       rdRspMine;
    logic       wrAckMine;
    logic       rdRspErr;
    logic       wrAckErr;

    assign rdReqTag = RD_TAG;
    assign wrReqTag = WR_TAG;

    // Ready stays low for the first cycle out of reset via readyEn.
    // readDataEn also blocks readRdy so the walker sees its data before
    // it may start another read.
    assign readRdy     = readyEn && (readState == IDLE) && !readDataEn && !rdReqAlmFull;
    assign writeRdy    = readyEn && (wrCnt < 4'(MAX_WRITES)) && !wrReqAlmFull && !wrReqValid;
    assign readAccept  = readEn && readRdy;
    assign writeAccept = writeEn && writeRdy;

    // Responses on the shared channels are only ours when the tag matches.
    assign rdRspMine = rdRspValid && (rdRspTag == RD_TAG);
    assign wrAckMine = wrRspValid && (wrRspTag == WR_TAG);
    assign rdRspErr  = rdRspMine && (readState != WAIT);
    assign wrAckErr  = wrAckMine && (wrCnt == 4'd0);

    // Read FSM next-state
    always_comb begin
        readStateNext = readState;
        case (readState)
            IDLE: begin
                if (readAccept) readStateNext = ISSUE;
                else            readStateNext = IDLE;
            end
            ISSUE: readStateNext = WAIT;
            WAIT: begin
                if (rdRspMine) readStateNext = IDLE;
                else           readStateNext = WAIT;
            end
            default: readStateNext = IDLE;
        endcase
    end

    // Outstanding-write count; an unmatched ack at zero never wraps
    always_comb begin
        wrCntNext = wrCnt;
        if (writeAccept && !wrAckMine) begin
            wrCntNext = wrCnt + 4'd1;
        end else if (!writeAccept && wrAckMine) begin
            wrCntNext = (wrCnt == 4'd0) ? 4'd0 : (wrCnt - 4'd1);
        end else if (writeAccept && wrAckMine && (wrCnt == 4'd0)) begin
            wrCntNext = 4'd1;
        end else begin
            wrCntNext = wrCnt;
        end
    end

    // Control state, counters and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readState     <= IDLE;
            wrCnt         <= 4'd0;
            readyEn       <= 1'b0;
            errUnexpected <= 1'b0;
        end else begin
            readState     <= readStateNext;
            wrCnt         <= wrCntNext;
            readyEn       <= 1'b1;
            errUnexpected <= errUnexpected || rdRspErr || wrAckErr;
        end
    end

    // Read request and returned-line registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdReqValid <= 1'b0;
            rdReqAddr  <= 42'd0;
            readDataEn <= 1'b0;
            readData   <= 512'd0;
        end else begin
            rdReqValid <= readAccept;
            if (readAccept) rdReqAddr <= readAddr;
            readDataEn <= rdRspMine && (readState == WAIT);
            if (rdRspMine && (readState == WAIT)) readData <= rdRspData;
        end
    end

    // Write request registers; the message occupies the low 64 bits of the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrReqValid <= 1'b0;
            wrReqAddr  <= 42'd0;
            wrReqData  <= 512'd0;
        end else begin
            wrReqValid <= writeAccept;
            if (writeAccept) begin
                wrReqAddr <= writeAddr;
                wrReqData <= {448'd0, writeData};
            end
        end
    end

endmodule

// File: tb/tb_cci_mpf_shim_vtp_pt_fim_port.sv
// Directed bench: a per-cycle vector table for the main read/write flow,
// then hand sequences for the write limit, counter corners and reset mid-read.
module tb_cci_mpf_shim_vtp_pt_fim_port;

    logic         clk;
    logic         reset_n;
    logic         readEn;
    logic [41:0]  readAddr;
    logic         readRdy;
    logic         readDataEn;
    logic [511:0] readData;
    logic         writeEn;
    logic [41:0]  writeAddr;
    logic [63:0]  writeData;
    logic         writeRdy;
    logic         rdReqValid;
    logic [41:0]  rdReqAddr;
    logic [15:0]  rdReqTag;
    logic         rdReqAlmFull;
    logic         rdRspValid;
    logic [15:0]  rdRspTag;
    logic [511:0] rdRspData;
    logic         wrReqValid;
    logic [41:0]  wrReqAddr;
    logic [15:0]  wrReqTag;
    logic [511:0] wrReqData;
    logic         wrReqAlmFull;
    logic         wrRspValid;
    logic [15:0]  wrRspTag;
    logic         errUnexpected;

    int passCnt  = 0;
    int totalCnt = 0;

    cci_mpf_shim_vtp_pt_fim_port dut (
        .clk(clk), .reset_n(reset_n),
        .readEn(readEn), .readAddr(readAddr), .readRdy(readRdy),
        .readDataEn(readDataEn), .readData(readData),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData), .writeRdy(writeRdy),
        .rdReqValid(rdReqValid), .rdReqAddr(rdReqAddr), .rdReqTag(rdReqTag),
        .rdReqAlmFull(rdReqAlmFull),
        .rdRspValid(rdRspValid), .rdRspTag(rdRspTag), .rdRspData(rdRspData),
        .wrReqValid(wrReqValid), .wrReqAddr(wrReqAddr), .wrReqTag(wrReqTag),
        .wrReqData(wrReqData), .wrReqAlmFull(wrReqAlmFull),
        .wrRspValid(wrRspValid), .wrRspTag(wrRspTag),
        .errUnexpected(errUnexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rEn;  logic [41:0] rAddr; logic rAF;
        logic        rsV;  logic [15:0] rsTag; logic [63:0] rsData;
        logic        wEn;  logic [41:0] wAddr; logic [63:0] wData; logic wAF;
        logic        waV;  logic [15:0] waTag;
        logic        eRRdy; logic eRqV; logic [41:0] eRqA; logic eRdEn; logic [63:0] eRd;
        logic        eWRdy; logic eWqV; logic [41:0] eWqA; logic [63:0] eWqD; logic eErr;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " readRdy"},       512'(readRdy),       512'd0);
        check({tag, " writeRdy"},      512'(writeRdy),      512'd0);
        check({tag, " readDataEn"},    512'(readDataEn),    512'd0);
        check({tag, " rdReqValid"},    512'(rdReqValid),    512'd0);
        check({tag, " wrReqValid"},    512'(wrReqValid),    512'd0);
        check({tag, " errUnexpected"}, 512'(errUnexpected), 512'd0);
        check({tag, " readData"},      readData,            512'd0);
        check({tag, " rdReqAddr"},     512'(rdReqAddr),     512'd0);
        check({tag, " wrReqAddr"},     512'(wrReqAddr),     512'd0);
    endtask

    task automatic idleInputs();
        readEn = 1'b0; readAddr = 42'd0; rdReqAlmFull = 1'b0;
        rdRspValid = 1'b0; rdRspTag = 16'd0; rdRspData = 512'd0;
        writeEn = 1'b0; writeAddr = 42'd0; writeData = 64'd0; wrReqAlmFull = 1'b0;
        wrRspValid = 1'b0; wrRspTag = 16'd0;
    endtask

    function automatic vec_t blankVec();
        vec_t v;
        v.rEn = 1'b0; v.rAddr = 42'd0; v.rAF = 1'b0;
        v.rsV = 1'b0; v.rsTag = 16'd0; v.rsData = 64'd0;
        v.wEn = 1'b0; v.wAddr = 42'd0; v.wData = 64'd0; v.wAF = 1'b0;
        v.waV = 1'b0; v.waTag = 16'd0;
        v.eRRdy = 1'b0; v.eRqV = 1'b0; v.eRqA = 42'd0; v.eRdEn = 1'b0; v.eRd = 64'd0;
        v.eWRdy = 1'b0; v.eWqV = 1'b0; v.eWqA = 42'd0; v.eWqD = 64'd0; v.eErr = 1'b0;
        return v;
    endfunction

    task automatic doReset();
        @(negedge clk);
        idleInputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [15:0] tag);
        wrRspValid = 1'b1; wrRspTag = tag;
        @(posedge clk); #1;
        wrRspValid = 1'b0; wrRspTag = 16'd0;
    endtask

    initial begin
        vec_t v;
        string nm;
        int n;
        idleInputs();
        reset_n = 1'b0;

        // Table: main read flow, foreign tag, concurrent write, backpressure, ack corners
        for (int i = 0; i < 13; i++) vecs[i] = blankVec();
        vecs[1].rEn = 1'b1; vecs[1].rAddr = 42'h123456; vecs[1].eRRdy = 1'b1; vecs[1].eWRdy = 1'b1;
        vecs[2].wEn = 1'b1; vecs[2].wAddr = 42'h3FF; vecs[2].wData = 64'hDEADBEEF_CAFEF00D;
        vecs[2].eRqV = 1'b1; vecs[2].eRqA = 42'h123456; vecs[2].eWRdy = 1'b1;
        vecs[3].rsV = 1'b1; vecs[3].rsTag = 16'h0005; vecs[3].rsData = 64'h55;
        vecs[3].eRqA = 42'h123456; vecs[3].eWqV = 1'b1; vecs[3].eWqA = 42'h3FF;
        vecs[3].eWqD = 64'hDEADBEEF_CAFEF00D;
        vecs[4].rsV = 1'b1; vecs[4].rsTag = 16'hF0A0; vecs[4].rsData = 64'hAB;
        vecs[4].eRqA = 42'h123456; vecs[4].eWRdy = 1'b1; vecs[4].eWqA = 42'h3FF;
        vecs[4].eWqD = 64'hDEADBEEF_CAFEF00D;
        for (int i = 5; i < 13; i++) begin
            vecs[i].eRqA = 42'h123456; vecs[i].eWqA = 42'h3FF;
            vecs[i].eWqD = 64'hDEADBEEF_CAFEF00D; vecs[i].eRd = 64'hAB;
            vecs[i].eRRdy = 1'b1; vecs[i].eWRdy = 1'b1;
        end
        vecs[5].eRRdy = 1'b0; vecs[5].eRdEn = 1'b1;
        vecs[7].rAF = 1'b1; vecs[7].wAF = 1'b1; vecs[7].rEn = 1'b1; vecs[7].wEn = 1'b1;
        vecs[7].rAddr = 42'h777; vecs[7].wAddr = 42'h777; vecs[7].wData = 64'h1234;
        vecs[7].eRRdy = 1'b0; vecs[7].eWRdy = 1'b0;
        vecs[9].waV = 1'b1;  vecs[9].waTag = 16'hF0A1;
        vecs[10].waV = 1'b1; vecs[10].waTag = 16'h0007;
        vecs[11].waV = 1'b1; vecs[11].waTag = 16'hF0A1;
        vecs[12].eErr = 1'b1;

        @(negedge clk);
        @(negedge clk);
        #1;
        checkAllZero("inReset");

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) reset_n = 1'b1;
            v = vecs[i];
            readEn = v.rEn; readAddr = v.rAddr; rdReqAlmFull = v.rAF;
            rdRspValid = v.rsV; rdRspTag = v.rsTag; rdRspData = {448'd0, v.rsData};
            writeEn = v.wEn; writeAddr = v.wAddr; writeData = v.wData; wrReqAlmFull = v.wAF;
            wrRspValid = v.waV; wrRspTag = v.waTag;
            #1;
            nm = $sformatf("v%0d", i);
            check({nm, " readRdy"},    512'(readRdy),    512'(v.eRRdy));
            check({nm, " rdReqValid"}, 512'(rdReqValid), 512'(v.eRqV));
            check({nm, " rdReqAddr"},  512'(rdReqAddr),  512'(v.eRqA));
            check({nm, " readDataEn"}, 512'(readDataEn), 512'(v.eRdEn));
            check({nm, " readData"},   readData,         {448'd0, v.eRd});
            check({nm, " writeRdy"},   512'(writeRdy),   512'(v.eWRdy));
            check({nm, " wrReqValid"}, 512'(wrReqValid), 512'(v.eWqV));
            check({nm, " wrReqAddr"},  512'(wrReqAddr),  512'(v.eWqA));
            check({nm, " wrReqData"},  wrReqData,        {448'd0, v.eWqD});
            check({nm, " err"},        512'(errUnexpected), 512'(v.eErr));
            if (v.eRqV) check({nm, " rdReqTag"}, 512'(rdReqTag), 512'(16'hF0A0));
            if (v.eWqV) check({nm, " wrReqTag"}, 512'(wrReqTag), 512'(16'hF0A1));
        end

        // Write limit: four writes with no acks, then one ack reopens the window
        doReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n = 0;
            while (!writeRdy && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
            check($sformatf("wl%0d writeRdy", i), 512'(writeRdy), 512'd1);
            writeEn = 1'b1; writeAddr = 42'(64'h1000 + i); writeData = 64'hA5A5_0000_0000_0000 + 64'(i);
            @(posedge clk); #1;
            writeEn = 1'b0;
            check($sformatf("wl%0d wrReqValid", i), 512'(wrReqValid), 512'd1);
            check($sformatf("wl%0d wrReqAddr", i), 512'(wrReqAddr), 512'(42'(64'h1000 + i)));
            check($sformatf("wl%0d wrReqData", i), wrReqData,
                  {448'd0, 64'hA5A5_0000_0000_0000 + 64'(i)});
        end
        @(negedge clk); #1;
        check("wl full writeRdy a", 512'(writeRdy), 512'd0);
        @(negedge clk); #1;
        check("wl full wrReqValid", 512'(wrReqValid), 512'd0);
        check("wl full writeRdy b", 512'(writeRdy), 512'd0);
        ack(16'hF0A1);
        check("wl after ack writeRdy", 512'(writeRdy), 512'd1);

        // Issue and ack together at count 2, then drain and underflow
        ack(16'hF0A1);
        check("cnt at 2", 512'(dut.wrCnt), 512'd2);
        writeEn = 1'b1; writeAddr = 42'h55; writeData = 64'h99;
        wrRspValid = 1'b1; wrRspTag = 16'hF0A1;
        @(posedge clk); #1;
        writeEn = 1'b0; wrRspValid = 1'b0;
        check("simul wrReqValid", 512'(wrReqValid), 512'd1);
        check("simul cnt", 512'(dut.wrCnt), 512'd2);
        ack(16'hF0A1);
        ack(16'hF0A1);
        check("drain cnt", 512'(dut.wrCnt), 512'd0);
        check("drain err", 512'(errUnexpected), 512'd0);
        ack(16'hF0A1);
        check("underflow err", 512'(errUnexpected), 512'd1);
        check("underflow cnt", 512'(dut.wrCnt), 512'd0);

        // Reset while a read is outstanding, then a stale response arrives
        doReset();
        check("rr readRdy", 512'(readRdy), 512'd1);
        readEn = 1'b1; readAddr = 42'h2AB;
        @(posedge clk); #1;
        readEn = 1'b0;
        check("rr rdReqValid", 512'(rdReqValid), 512'd1);
        @(posedge clk); #1;
        check("rr in wait readRdy", 512'(readRdy), 512'd0);
        reset_n = 1'b0;
        #1;
        checkAllZero("midReset");
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rdRspValid = 1'b1; rdRspTag = 16'hF0A0; rdRspData = 512'h77;
        @(posedge clk); #1;
        rdRspValid = 1'b0;
        check("stale err", 512'(errUnexpected), 512'd1);
        check("stale readDataEn", 512'(readDataEn), 512'd0);
        check("stale readData", readData, 512'd0);
        check("stale readRdy", 512'(readRdy), 512'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
